mux_scan_sequencer: RTL and testbench

//   Round-robin channel scanner that drives the sel input of a 4:1 mux (mux_4_1)
//   and captures the mux output y on the next clock edge.

---
 rtl/mux_scan_sequencer.sv | 103 ++++++++++
 tb/tb_mux_scan_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Round-robin scanner for a 4:1 mux: drives sel, captures mux_y one edge later
// and presents {channel, data} on a registered valid/ready output.
module mux_scan_sequencer #(
  parameter int unsigned W     = 4,
  parameter int unsigned DWELL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   ch_en,
  input  logic [W-1:0] mux_y,
  output logic [1:0]   sel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_chan
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = (DWELL > 0) ? CW'(DWELL - 1) : '0;

  typedef enum logic {
    ST_SAMPLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t         r_state, w_state_n;
  logic [CW-1:0]  r_count, w_count_n;
  logic [1:0]     r_sel, w_sel_n;
  logic           r_valid, w_valid_n;
  logic [W-1:0]   r_data, w_data_n;
  logic [1:0]     r_chan, w_chan_n;
  logic           w_capture;
  logic           w_step;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SAMPLE;
      r_count <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_sel   <= w_sel_n;
      r_valid <= w_valid_n;
      r_data  <= w_data_n;
      r_chan  <= w_chan_n;
    end
  end

  // Next-state: settle countdown, skip/capture/stall decision, handshake
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_sel_n   = r_sel;
    w_valid_n = r_valid;
    w_data_n  = r_data;
    w_chan_n  = r_chan;
    w_capture = 1'b0;
    w_step    = 1'b0;

    case (r_state)
      ST_SETTLE: begin
        if (r_count == '0) w_state_n = ST_SAMPLE;
        else               w_count_n = r_count - CW'(1);
      end
      ST_SAMPLE: begin
        if (ch_en != 4'b0000) begin
          if (!ch_en[r_sel]) begin
            w_step = 1'b1;
          end else if (!r_valid || out_ready) begin
            w_capture = 1'b1;
            w_step    = 1'b1;
            w_data_n  = mux_y;
            w_chan_n  = r_sel;
            w_valid_n = 1'b1;
          end
        end
      end
      default: w_state_n = ST_SAMPLE;
    endcase

    if (w_step) begin
      w_sel_n = r_sel + 2'd1;
      if (DWELL > 0) begin
        w_state_n = ST_SETTLE;
        w_count_n = DWELL_LOAD;
      end
    end

    // A capture in the same cycle as an accept replaces the sample without a bubble
    if (r_valid && out_ready && !w_capture) w_valid_n = 1'b0;
  end

  assign sel       = r_sel;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: one DWELL=0 and one DWELL=2 instance,
// each fed by a 4:1 mux model with d0..d3 = A,B,C,D.
module tb_mux_scan_sequencer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ch_en;
  logic         out_ready;

  logic [1:0]   sel0, chan0, sel2, chan2;
  logic         valid0, valid2;
  logic [W-1:0] data0, data2, y0, y2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Mux models: input i carries 4'hA + i
  assign y0 = W'(4'hA + {2'b00, sel0});
  assign y2 = W'(4'hA + {2'b00, sel2});

  mux_scan_sequencer #(.W(W), .DWELL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .mux_y(y0), .sel(sel0),
    .out_valid(valid0), .out_ready(out_ready), .out_data(data0), .out_chan(chan0)
  );

  mux_scan_sequencer #(.W(W), .DWELL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .mux_y(y2), .sel(sel2),
    .out_valid(valid2), .out_ready(out_ready), .out_data(data2), .out_chan(chan2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic check0(input string tag, input logic v, input logic [1:0] c,
                        input logic [1:0] s);
    check({tag, "_valid"}, 32'(valid0), 32'(v));
    check({tag, "_sel"}, 32'(sel0), 32'(s));
    if (v) begin
      check({tag, "_chan"}, 32'(chan0), 32'(c));
      check({tag, "_data"}, 32'(data0), 32'(4'hA + {2'b00, c}));
    end
  endtask

  task automatic check2(input string tag, input logic v, input logic [1:0] c,
                        input logic [1:0] s);
    check({tag, "_valid"}, 32'(valid2), 32'(v));
    check({tag, "_sel"}, 32'(sel2), 32'(s));
    if (v) begin
      check({tag, "_chan"}, 32'(chan2), 32'(c));
      check({tag, "_data"}, 32'(data2), 32'(4'hA + {2'b00, c}));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ch_en     = 4'hF;
    out_ready = 1'b1;
    step();
    step();
    // Reset state of both instances
    check("rst_sel0", 32'(sel0), 32'h0);
    check("rst_valid0", 32'(valid0), 32'h0);
    check("rst_data0", 32'(data0), 32'h0);
    check("rst_chan0", 32'(chan0), 32'h0);
    check("rst_valid2", 32'(valid2), 32'h0);
    check("rst_sel2", 32'(sel2), 32'h0);

    // Test 1: all channels, back-to-back samples
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check0("t1", 1'b1, 2'(i), 2'(i + 1));
    end

    // Test 2: only channels 1 and 3, one skip cycle between samples
    ch_en = 4'b1010;
    do_reset();
    step(); check0("t2_skip0", 1'b0, 2'd0, 2'd1);
    step(); check0("t2_b",     1'b1, 2'd1, 2'd2);
    step(); check0("t2_skip2", 1'b0, 2'd0, 2'd3);
    step(); check0("t2_d",     1'b1, 2'd3, 2'd0);
    step(); check0("t2_skip0b",1'b0, 2'd0, 2'd1);
    step(); check0("t2_b2",    1'b1, 2'd1, 2'd2);

    // Test 3: DWELL=2, sel held three cycles per channel
    ch_en = 4'hF;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(); check2("t3_cap",  1'b1, 2'(k), 2'(k + 1));
      step(); check2("t3_set1", 1'b0, 2'd0, 2'(k + 1));
      step(); check2("t3_set2", 1'b0, 2'd0, 2'(k + 1));
    end

    // Test 4: stall after first capture, then release without loss or duplicate
    do_reset();
    step(); check0("t4_a", 1'b1, 2'd0, 2'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); check0("t4_stall", 1'b1, 2'd0, 2'd1);
    end
    out_ready = 1'b1;
    step(); check0("t4_b", 1'b1, 2'd1, 2'd2);
    step(); check0("t4_c", 1'b1, 2'd2, 2'd3);

    // Test 5: no channel enabled freezes sel and drains the sample
    ch_en = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step(); check0("t5_idle", 1'b0, 2'd0, 2'd3);
    end
    ch_en = 4'b0100;
    step(); check0("t5_skip3", 1'b0, 2'd0, 2'd0);
    step(); check0("t5_skip0", 1'b0, 2'd0, 2'd1);
    step(); check0("t5_skip1", 1'b0, 2'd0, 2'd2);
    step(); check0("t5_c",     1'b1, 2'd2, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step(); check0("t5_gap", 1'b0, 2'd0, 2'(i));
    end
    step(); check0("t5_c2", 1'b1, 2'd2, 2'd3);

    // Test 6: reset while DWELL=2 instance is stalled mid-settle
    ch_en = 4'hF;
    do_reset();
    out_ready = 1'b0;
    step(); check2("t6_a",      1'b1, 2'd0, 2'd1);
    step(); check2("t6_settle", 1'b1, 2'd0, 2'd1);
    rst_n = 1'b0;
    step();
    check("t6_rst_sel", 32'(sel2), 32'h0);
    check("t6_rst_valid", 32'(valid2), 32'h0);
    check("t6_rst_data", 32'(data2), 32'h0);
    check("t6_rst_chan", 32'(chan2), 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(); check2("t6_restart", 1'b1, 2'd0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
